// File: rtl/serial_mag_comp_ctrl_if.sv
// serial_mag_comp_ctrl_if: request/result and shared-comparator signals of the nibble-serial compare controller
interface serial_mag_comp_ctrl_if #(parameter int NIB = 4);
    logic             start;
    logic [4*NIB-1:0] a;
    logic [4*NIB-1:0] b;
    logic [3:0]       comp_a;
    logic [3:0]       comp_b;
    logic             comp_l;
    logic             comp_e;
    logic             comp_m;
    logic             busy;
    logic             done;
    logic             l;
    logic             e;
    logic             m;
    logic             err;
    modport master (
        output start, a, b, comp_l, comp_e, comp_m,
        input  comp_a, comp_b, busy, done, l, e, m, err
    );
    modport slave (
        input  start, a, b, comp_l, comp_e, comp_m,
        output comp_a, comp_b, busy, done, l, e, m, err
    );
endinterface

// File: rtl/serial_mag_comp_ctrl.sv
// serial_mag_comp_ctrl: walks two wide operands MSB nibble first through one shared 4-bit comparator
module serial_mag_comp_ctrl #(
    parameter int NIB = 4
) (
    input logic clk,
    input logic rst,
    serial_mag_comp_ctrl_if.slave bus
);
    localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [4*NIB-1:0] a_q, b_q, a_sh, b_sh;
    logic [IW-1:0] idx;
    logic l_q, e_q, m_q, err_q;
    logic bad, last, decide;
    assign bad    = !$onehot({bus.comp_l, bus.comp_e, bus.comp_m});
    assign last   = idx == '0;
    assign decide = bad || bus.comp_m || bus.comp_l || last;
    assign a_sh   = a_q >> {idx, 2'b00};
    assign b_sh   = b_q >> {idx, 2'b00};
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    // next state: RUN exits on the first unequal nibble, a bad comparator response or the last nibble
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.start ? RUN : IDLE;
            RUN:     state_nx = decide ? DONE : RUN;
            default: state_nx = IDLE;
        endcase
    end
    // outputs: comparator is only fed while running, otherwise held at zero
    always_comb begin
        bus.busy   = state == RUN;
        bus.done   = state == DONE;
        bus.comp_a = (state == RUN) ? a_sh[3:0] : 4'h0;
        bus.comp_b = (state == RUN) ? b_sh[3:0] : 4'h0;
    end
    // operand capture, nibble index and sticky one-hot result flags
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            idx   <= '0;
            l_q   <= 1'b0;
            e_q   <= 1'b0;
            m_q   <= 1'b0;
            err_q <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            idx   <= IW'(NIB - 1);
            l_q   <= 1'b0;
            e_q   <= 1'b0;
            m_q   <= 1'b0;
            err_q <= 1'b0;
        end else if (state == RUN) begin
            if (bad)             err_q <= 1'b1;
            else if (bus.comp_m) m_q   <= 1'b1;
            else if (bus.comp_l) l_q   <= 1'b1;
            else if (last)       e_q   <= 1'b1;
            else                 idx   <= idx - IW'(1);
        end
    end
    assign bus.l   = l_q;
    assign bus.e   = e_q;
    assign bus.m   = m_q;
    assign bus.err = err_q;
endmodule

// File: tb/tb_serial_mag_comp_ctrl.sv
// tb_serial_mag_comp_ctrl: directed checks of the nibble-serial compare controller with a bench-side comparator
module tb_serial_mag_comp_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fault = 1'b0;
    int vec = 0;
    int miss = 0;
    logic [13:0] st;
    serial_mag_comp_ctrl_if #(.NIB(4)) bus ();
    serial_mag_comp_ctrl #(.NIB(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    // ideal comparator; fault forces l and m together with e low
    assign bus.comp_l = fault || (bus.comp_a < bus.comp_b);
    assign bus.comp_e = !fault && (bus.comp_a == bus.comp_b);
    assign bus.comp_m = fault || (bus.comp_a > bus.comp_b);
    // {busy, done, l, e, m, err, comp_a, comp_b}
    assign st = {bus.busy, bus.done, bus.l, bus.e, bus.m, bus.err, bus.comp_a, bus.comp_b};

    task automatic go(input logic [15:0] aa, input logic [15:0] bb);
        bus.a = aa;
        bus.b = bb;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b1;
        bus.a = 16'h5555;
        bus.b = 16'h1111;
        repeat (3) @(negedge clk);
        vec++;
        if (st !== 14'h0) begin miss++; $display("FAIL reset: got %h want %h", st, 14'h0); end
        bus.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        vec++;
        if (st !== 14'h0) begin miss++; $display("FAIL reset_idle: got %h want %h", st, 14'h0); end
    endtask

    task automatic test_equal();
        go(16'h1234, 16'h1234);
        bus.a = 16'hFFFF;
        bus.b = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            vec++;
            if (st !== {2'b10, 4'b0000, 4'(i + 1), 4'(i + 1)}) begin
                miss++; $display("FAIL equal_run%0d: got %h want %h", i, st, {2'b10, 4'b0000, 4'(i + 1), 4'(i + 1)});
            end
            @(negedge clk);
        end
        vec++;
        if (st !== {2'b01, 4'b0100, 8'h00}) begin miss++; $display("FAIL equal_done: got %h want %h", st, {2'b01, 4'b0100, 8'h00}); end
        @(negedge clk);
        vec++;
        if (st !== {2'b00, 4'b0100, 8'h00}) begin miss++; $display("FAIL equal_hold: got %h want %h", st, {2'b00, 4'b0100, 8'h00}); end
    endtask

    task automatic test_msb();
        go(16'h8000, 16'h7FFF);
        vec++;
        if (st !== {2'b10, 4'b0000, 4'h8, 4'h7}) begin miss++; $display("FAIL msb_run: got %h want %h", st, {2'b10, 4'b0000, 4'h8, 4'h7}); end
        @(negedge clk);
        vec++;
        if (st !== {2'b01, 4'b0010, 8'h00}) begin miss++; $display("FAIL msb_done: got %h want %h", st, {2'b01, 4'b0010, 8'h00}); end
        @(negedge clk);
        vec++;
        if (st !== {2'b00, 4'b0010, 8'h00}) begin miss++; $display("FAIL msb_hold: got %h want %h", st, {2'b00, 4'b0010, 8'h00}); end
    endtask

    task automatic test_mid();
        go(16'h12F4, 16'h1305);
        vec++;
        if (st !== {2'b10, 4'b0000, 4'h1, 4'h1}) begin miss++; $display("FAIL mid_run0: got %h want %h", st, {2'b10, 4'b0000, 4'h1, 4'h1}); end
        @(negedge clk);
        vec++;
        if (st !== {2'b10, 4'b0000, 4'h2, 4'h3}) begin miss++; $display("FAIL mid_run1: got %h want %h", st, {2'b10, 4'b0000, 4'h2, 4'h3}); end
        @(negedge clk);
        vec++;
        if (st !== {2'b01, 4'b1000, 8'h00}) begin miss++; $display("FAIL mid_done: got %h want %h", st, {2'b01, 4'b1000, 8'h00}); end
        @(negedge clk);
    endtask

    task automatic test_lsb();
        go(16'h1235, 16'h1234);
        repeat (3) @(negedge clk);
        vec++;
        if (st !== {2'b10, 4'b0000, 4'h5, 4'h4}) begin miss++; $display("FAIL lsb_run3: got %h want %h", st, {2'b10, 4'b0000, 4'h5, 4'h4}); end
        @(negedge clk);
        vec++;
        if (st !== {2'b01, 4'b0010, 8'h00}) begin miss++; $display("FAIL lsb_done: got %h want %h", st, {2'b01, 4'b0010, 8'h00}); end
        @(negedge clk);
    endtask

    task automatic test_fault();
        fault = 1'b1;
        go(16'h1234, 16'h1234);
        vec++;
        if (st !== {2'b10, 4'b0000, 4'h1, 4'h1}) begin miss++; $display("FAIL fault_run: got %h want %h", st, {2'b10, 4'b0000, 4'h1, 4'h1}); end
        @(negedge clk);
        fault = 1'b0;
        vec++;
        if (st !== {2'b01, 4'b0001, 8'h00}) begin miss++; $display("FAIL fault_done: got %h want %h", st, {2'b01, 4'b0001, 8'h00}); end
        @(negedge clk);
        vec++;
        if (st !== {2'b00, 4'b0001, 8'h00}) begin miss++; $display("FAIL fault_idle: got %h want %h", st, {2'b00, 4'b0001, 8'h00}); end
    endtask

    task automatic test_back_to_back();
        go(16'h0000, 16'h0001);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 16'hFFFF;
        bus.b = 16'h0000;
        @(negedge clk);
        bus.start = 1'b0;
        vec++;
        if (st !== {2'b10, 4'b0000, 4'h0, 4'h0}) begin miss++; $display("FAIL busy_run2: got %h want %h", st, {2'b10, 4'b0000, 4'h0, 4'h0}); end
        @(negedge clk);
        vec++;
        if (st !== {2'b10, 4'b0000, 4'h0, 4'h1}) begin miss++; $display("FAIL busy_run3: got %h want %h", st, {2'b10, 4'b0000, 4'h0, 4'h1}); end
        @(negedge clk);
        vec++;
        if (st !== {2'b01, 4'b1000, 8'h00}) begin miss++; $display("FAIL busy_done: got %h want %h", st, {2'b01, 4'b1000, 8'h00}); end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        vec++;
        if (st !== {2'b00, 4'b1000, 8'h00}) begin miss++; $display("FAIL busy_ignored: got %h want %h", st, {2'b00, 4'b1000, 8'h00}); end
        go(16'hFFFF, 16'h0000);
        vec++;
        if (st !== {2'b10, 4'b0000, 4'hF, 4'h0}) begin miss++; $display("FAIL fresh_run: got %h want %h", st, {2'b10, 4'b0000, 4'hF, 4'h0}); end
        @(negedge clk);
        vec++;
        if (st !== {2'b01, 4'b0010, 8'h00}) begin miss++; $display("FAIL fresh_done: got %h want %h", st, {2'b01, 4'b0010, 8'h00}); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic seen;
        go(16'h1234, 16'h1234);
        @(negedge clk);
        vec++;
        if (st !== {2'b10, 4'b0000, 4'h2, 4'h2}) begin miss++; $display("FAIL rstmid_run1: got %h want %h", st, {2'b10, 4'b0000, 4'h2, 4'h2}); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vec++;
        if (st !== 14'h0) begin miss++; $display("FAIL rstmid_idle: got %h want %h", st, 14'h0); end
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | bus.done | bus.busy;
        end
        vec++;
        if (seen !== 1'b0) begin miss++; $display("FAIL rstmid_nodone: got %b want %b", seen, 1'b0); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        test_reset();
        test_equal();
        test_msb();
        test_mid();
        test_lsb();
        test_fault();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
